// File: rtl/lstm_mem_pkg.sv
// Shared types and constants for the LSTM cell-state memory sequencer.
package lstm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2
  } state_e;

  localparam int DEF_NUM_LSTM = 53;
  localparam int DEF_TIMESTEP = 7;
  localparam int DEF_AW       = 9;

  typedef logic [DEF_AW-1:0] addr_t;

  // Slot t=0 holds the preloaded c0, hence TIMESTEP+1 slots per unit.
  function automatic int mem_depth(input int num_lstm, input int timestep);
    return num_lstm * (timestep + 1);
  endfunction

endpackage

// File: rtl/memc_unit_step_cnt.sv
// Nested (unit, timestep) counter for the forward phase; o_last flags the final beat.
module memc_unit_step_cnt #(
  parameter int NUM_LSTM = 53,
  parameter int TIMESTEP = 7,
  parameter int UW       = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1,
  parameter int TW       = (TIMESTEP > 0) ? $clog2(TIMESTEP + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_step,
  output logic [UW-1:0] o_u,
  output logic [TW-1:0] o_t,
  output logic          o_last
);

  logic [UW-1:0] r_u;
  logic [TW-1:0] r_t;
  logic          w_u_wrap;

  assign w_u_wrap = (r_u == UW'(NUM_LSTM - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_u <= '0;
      r_t <= '0;
    end else if (i_clr) begin
      r_u <= '0;
      r_t <= '0;
    end else if (i_step) begin
      if (w_u_wrap) begin
        r_u <= '0;
        r_t <= r_t + 1'b1;
      end else begin
        r_u <= r_u + 1'b1;
      end
    end
  end

  assign o_u    = r_u;
  assign o_t    = r_t;
  assign o_last = w_u_wrap && (r_t == TW'(TIMESTEP - 1));

endmodule

// File: rtl/memory_c_seq.sv
// LSTM c_t memory sequencer: forward write/prev-read phase and reverse backward replay.
// Define MEMC_SEQ_ERR_EN to enable the sticky protocol-error flag on err.
module memory_c_seq
  import lstm_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_LSTM = DEF_NUM_LSTM,
  parameter int TIMESTEP = DEF_TIMESTEP,
  parameter int AW       = DEF_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fwd_start,
  input  logic                    bwd_start,
  input  logic                    fw_req,
  input  logic signed [WIDTH-1:0] fw_data,
  output logic                    fw_ack,
  output logic signed [WIDTH-1:0] fw_prev,
  input  logic                    bw_req,
  output logic                    bw_ack,
  output logic signed [WIDTH-1:0] bw_data,
  output logic                    bw_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    mem_wr,
  output logic [AW-1:0]           mem_wr_addr,
  output logic [AW-1:0]           mem_rd_addr,
  output logic signed [WIDTH-1:0] mem_i,
  input  logic signed [WIDTH-1:0] mem_o
);

  localparam int DEPTH = mem_depth(NUM_LSTM, TIMESTEP);
  localparam int UW    = (NUM_LSTM > 1) ? $clog2(NUM_LSTM) : 1;
  localparam int TW    = (TIMESTEP > 0) ? $clog2(TIMESTEP + 1) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] NL_A      = AW'(NUM_LSTM);

  state_e                  r_state, w_state_nxt;
  logic [AW-1:0]           r_bw_ptr;
  logic signed [WIDTH-1:0] r_bw_data;
  logic                    r_bw_valid;
  logic                    r_done;
  logic                    w_cnt_clr;
  logic                    w_last;
  logic [UW-1:0]           w_u;
  logic [TW-1:0]           w_t;
  logic [AW-1:0]           w_rd_base;
  logic [AW-1:0]           w_wr_ptr;
  logic                    w_bw_load;

  memc_unit_step_cnt #(
    .NUM_LSTM (NUM_LSTM),
    .TIMESTEP (TIMESTEP),
    .UW       (UW),
    .TW       (TW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_step (fw_ack),
    .o_u    (w_u),
    .o_t    (w_t),
    .o_last (w_last)
  );

  // c_{t-1} lives one NUM_LSTM-row below the c_t being written.
  assign w_rd_base = AW'(w_t) * NL_A + AW'(w_u);
  assign w_wr_ptr  = w_rd_base + NL_A;
  assign w_bw_load = (r_state == IDLE) && !fwd_start && bwd_start;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    fw_ack      = 1'b0;
    bw_ack      = 1'b0;
    mem_wr      = 1'b0;
    mem_wr_addr = '0;
    mem_rd_addr = '0;
    mem_i       = '0;
    fw_prev     = '0;
    case (r_state)
      IDLE: begin
        if (fwd_start) begin
          w_state_nxt = FWD;
          w_cnt_clr   = 1'b1;
        end else if (bwd_start) begin
          w_state_nxt = BWD;
        end
      end
      FWD: begin
        fw_ack      = fw_req;
        mem_wr      = fw_req;
        mem_wr_addr = w_wr_ptr;
        mem_rd_addr = w_rd_base;
        mem_i       = fw_data;
        fw_prev     = mem_o;
        if (fw_req && w_last) w_state_nxt = IDLE;
      end
      BWD: begin
        bw_ack      = bw_req;
        mem_rd_addr = r_bw_ptr;
        if (bw_req && (r_bw_ptr == '0)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bw_ptr   <= '0;
      r_bw_data  <= '0;
      r_bw_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bw_valid <= bw_ack;
      r_done     <= (fw_ack && w_last) || (bw_ack && (r_bw_ptr == '0));
      if (w_bw_load) r_bw_ptr <= LAST_ADDR;
      else if (bw_ack) r_bw_ptr <= r_bw_ptr - 1'b1;
      if (bw_ack) r_bw_data <= mem_o;
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign bw_valid = r_bw_valid;
  assign bw_data  = r_bw_data;

`ifdef MEMC_SEQ_ERR_EN
  logic r_err;
  logic w_err_evt;

  assign w_err_evt = (fw_req && (r_state != FWD)) ||
                     (bw_req && (r_state != BWD)) ||
                     ((fwd_start || bwd_start) && (r_state != IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_c_seq.sv
// Scoreboard bench for memory_c_seq with a small behavioural memory (NUM_LSTM=3, TIMESTEP=2).
module tb_memory_c_seq;

  localparam int NL = 3;
  localparam int TS = 2;
  localparam int AWT = 4;
  localparam int W = 32;
  localparam int DEPTH = NL * (TS + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fwd_start = 1'b0;
  logic bwd_start = 1'b0;
  logic fw_req = 1'b0;
  logic bw_req = 1'b0;
  logic signed [W-1:0] fw_data = '0;
  logic fw_ack, bw_ack, bw_valid, busy, done, err, mem_wr;
  logic signed [W-1:0] fw_prev, bw_data, mem_i, mem_o;
  logic [AWT-1:0] mem_wr_addr, mem_rd_addr;

  logic signed [W-1:0] mem [0:15];
  logic signed [W-1:0] exp_mem [0:15];
  logic [AWT+W-1:0] wq[$];
  logic signed [W-1:0] bq[$];

  int n_tests = 0;
  int n_fail = 0;

  memory_c_seq #(.WIDTH(W), .NUM_LSTM(NL), .TIMESTEP(TS), .AW(AWT)) dut (
    .clk(clk), .rst(rst), .fwd_start(fwd_start), .bwd_start(bwd_start),
    .fw_req(fw_req), .fw_data(fw_data), .fw_ack(fw_ack), .fw_prev(fw_prev),
    .bw_req(bw_req), .bw_ack(bw_ack), .bw_data(bw_data), .bw_valid(bw_valid),
    .busy(busy), .done(done), .err(err), .mem_wr(mem_wr),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_i(mem_i), .mem_o(mem_o)
  );

  always #5 clk = ~clk;

  assign mem_o = mem[mem_rd_addr];
  always @(posedge clk) if (mem_wr) mem[mem_wr_addr] <= mem_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, err, mem_wr, bw_valid, fw_ack, bw_ack} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, err, mem_wr, bw_valid, fw_ack, bw_ack});
    end
    n_tests++;
    if ({mem_wr_addr, mem_rd_addr} !== 8'h00 || bw_data !== 0 || mem_i !== 0 || fw_prev !== 0) begin
      n_fail++;
      $display("FAIL reset_data: wa=%0d ra=%0d bw_data=%0d mem_i=%0d prev=%0d want all 0",
               mem_wr_addr, mem_rd_addr, bw_data, mem_i, fw_prev);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs a full forward pass, fw_req held high; data base+0..base+5.
  task automatic run_fwd_pass(input int base, input string tag);
    logic [AWT+W-1:0] exp;
    @(negedge clk); fwd_start = 1'b1;
    @(negedge clk); fwd_start = 1'b0;
    for (int k = 0; k < NL * TS; k++) begin
      fw_req = 1'b1;
      fw_data = W'(base + k);
      wq.push_back({AWT'(NL + k), W'(base + k)});
      #1;
      n_tests++;
      if (fw_ack !== 1'b1 || mem_wr !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_ack k=%0d: ack=%b wr=%b done=%b want 1 1 0", tag, k, fw_ack, mem_wr, done);
      end
      n_tests++;
      if (mem_rd_addr !== AWT'(k) || fw_prev !== exp_mem[k]) begin
        n_fail++;
        $display("FAIL %s_prev k=%0d: ra=%0d prev=%0d want ra=%0d prev=%0d", tag, k, mem_rd_addr, fw_prev, k, exp_mem[k]);
      end
      exp = wq.pop_front();
      exp_mem[NL + k] = W'(base + k);
      n_tests++;
      if ({mem_wr_addr, mem_i} !== exp) begin
        n_fail++;
        $display("FAIL %s_write k=%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                 tag, k, mem_wr_addr, mem_i, exp[AWT+W-1:W], $signed(exp[W-1:0]));
      end
      @(negedge clk);
    end
    fw_req = 1'b0;
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: done=%b busy=%b wr=%b want 1 0 0", tag, done, busy, mem_wr);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done=%b want 0", tag, done);
    end
  endtask

  task automatic test_fwd_stream();
    run_fwd_pass(10, "fwd");
  endtask

  task automatic test_bwd();
    logic signed [W-1:0] exp;
    @(negedge clk); bwd_start = 1'b1;
    @(negedge clk); bwd_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bw_req = 1'b1;
      bq.push_back(exp_mem[DEPTH - 1 - k]);
      #1;
      n_tests++;
      if (bw_ack !== 1'b1 || mem_wr !== 1'b0 || mem_rd_addr !== AWT'(DEPTH - 1 - k)) begin
        n_fail++;
        $display("FAIL bwd_addr k=%0d: ack=%b wr=%b ra=%0d want 1 0 %0d", k, bw_ack, mem_wr, mem_rd_addr, DEPTH - 1 - k);
      end
      @(negedge clk);
      exp = bq.pop_front();
      n_tests++;
      if (bw_valid !== 1'b1 || bw_data !== exp || done !== (k == DEPTH - 1)) begin
        n_fail++;
        $display("FAIL bwd_data k=%0d: valid=%b data=%0d done=%b want 1 %0d %b",
                 k, bw_valid, bw_data, done, exp, (k == DEPTH - 1));
      end
    end
    bw_req = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bwd_idle: busy=%b want 0", busy);
    end
    @(negedge clk);
    n_tests++;
    if (bw_valid !== 1'b0 || done !== 1'b0 || bw_data !== exp_mem[0]) begin
      n_fail++;
      $display("FAIL bwd_hold: valid=%b done=%b data=%0d want 0 0 %0d", bw_valid, done, bw_data, exp_mem[0]);
    end
  endtask

  task automatic test_both_start();
    @(negedge clk); fwd_start = 1'b1; bwd_start = 1'b1;
    @(negedge clk); fwd_start = 1'b0; bwd_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fw_req = 1'b1;
      fw_data = W'(30 + k);
      bw_req = (k == 0);
      #1;
      n_tests++;
      if (fw_ack !== 1'b1 || bw_ack !== 1'b0 || mem_wr_addr !== AWT'(NL + k) || mem_i !== W'(30 + k)) begin
        n_fail++;
        $display("FAIL both_fwd k=%0d: fw_ack=%b bw_ack=%b wa=%0d data=%0d want 1 0 %0d %0d",
                 k, fw_ack, bw_ack, mem_wr_addr, mem_i, NL + k, 30 + k);
      end
      exp_mem[NL + k] = W'(30 + k);
      @(negedge clk);
      bw_req = 1'b0;
    end
`ifdef MEMC_SEQ_ERR_EN
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_bwreq_in_fwd: err=%b want 1", err);
    end
`endif
  endtask

  task automatic test_mid_reset();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({busy, mem_wr, fw_ack, done, err} !== 5'b0 || {mem_wr_addr, mem_rd_addr} !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b wr=%b ack=%b done=%b err=%b wa=%0d ra=%0d want all 0",
               busy, mem_wr, fw_ack, done, err, mem_wr_addr, mem_rd_addr);
    end
    fw_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_fwd_pass(40, "restart");
  endtask

  task automatic test_fwd_toggle();
    int k;
    @(negedge clk); fwd_start = 1'b1;
    @(negedge clk); fwd_start = 1'b0;
    k = 0;
    for (int j = 0; j <= 2 * (NL * TS - 1); j++) begin
      fw_req = (j % 2 == 0);
      bwd_start = (j == 3);
      fwd_start = (j == 5);
      fw_data = W'(50 + k);
      #1;
      if (j % 2 == 0) begin
        n_tests++;
        if (mem_wr !== 1'b1 || mem_wr_addr !== AWT'(NL + k) || mem_rd_addr !== AWT'(k) || mem_i !== W'(50 + k)) begin
          n_fail++;
          $display("FAIL toggle_write j=%0d: wr=%b wa=%0d ra=%0d data=%0d want 1 %0d %0d %0d",
                   j, mem_wr, mem_wr_addr, mem_rd_addr, mem_i, NL + k, k, 50 + k);
        end
        exp_mem[NL + k] = W'(50 + k);
        k++;
      end else begin
        n_tests++;
        if (mem_wr !== 1'b0 || fw_ack !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL toggle_idle j=%0d: wr=%b ack=%b busy=%b want 0 0 1", j, mem_wr, fw_ack, busy);
        end
      end
      @(negedge clk);
    end
    fw_req = 1'b0; bwd_start = 1'b0; fwd_start = 1'b0;
    #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_done: done=%b busy=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_idle_reqs();
    @(negedge clk);
    fw_req = 1'b1; bw_req = 1'b1;
    #1;
    n_tests++;
    if ({mem_wr, fw_ack, bw_ack, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_reqs: wr=%b fw_ack=%b bw_ack=%b busy=%b want 0 0 0 0", mem_wr, fw_ack, bw_ack, busy);
    end
    @(negedge clk);
    fw_req = 1'b0; bw_req = 1'b0;
`ifdef MEMC_SEQ_ERR_EN
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_err: err=%b busy=%b want 1 0", err, busy);
    end
`else
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_err: err=%b busy=%b want 0 0", err, busy);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    mem[0] = -5; mem[1] = -6; mem[2] = -7;
    exp_mem[0] = -5; exp_mem[1] = -6; exp_mem[2] = -7;
    test_reset();
    test_fwd_stream();
    test_bwd();
    test_both_start();
    test_mid_reset();
    test_fwd_toggle();
    test_idle_reqs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
